// File: rtl/riscv_imm_decode_stage.sv
// RISC-V immediate decode stage: decodes the immediate and format of an instruction word
// and buffers results in a two-entry skid buffer with valid/ready handshakes on both sides.
module riscv_imm_decode_stage #(
  parameter int XLEN       = 32,
  parameter bit EN_CSR_IMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic [15:0]     illegal_cnt
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  logic            main_vld_q, main_vld_d;
  logic [XLEN-1:0] main_imm_q, main_imm_d;
  logic [2:0]      main_fmt_q, main_fmt_d;
  logic            main_ill_q, main_ill_d;
  logic            skid_vld_q, skid_vld_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [2:0]      skid_fmt_q, skid_fmt_d;
  logic            skid_ill_q, skid_ill_d;
  logic            in_ready_q, in_ready_d;
  logic [15:0]     cnt_q, cnt_d;

  logic            accept;
  logic            deliver;

  // Opcode classification and immediate assembly for the incoming word
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    unique case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: dec_fmt = FMT_I;
      7'b0100011:                                     dec_fmt = FMT_S;
      7'b1100011:                                     dec_fmt = FMT_B;
      7'b0110111, 7'b0010111:                         dec_fmt = FMT_U;
      7'b1101111:                                     dec_fmt = FMT_J;
      7'b0011011: begin
        if (XLEN == 64) dec_fmt = FMT_I;
        else            dec_ill = 1'b1;
      end
      7'b1110011: dec_fmt = (EN_CSR_IMM && inst[14]) ? FMT_Z : FMT_I;
      default:    dec_ill = 1'b1;
    endcase

    dec_imm = '0;
    unique case (dec_fmt)
      FMT_I: dec_imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      FMT_S: dec_imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: dec_imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: dec_imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
      FMT_J: dec_imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_Z: dec_imm = {{(XLEN-5){1'b0}}, inst[19:15]};
      default: dec_imm = '0;
    endcase
  end

  assign accept  = in_valid && in_ready_q;
  assign deliver = main_vld_q && out_ready;

  // Skid buffer next state; the skid entry only fills while main is stalled
  always_comb begin
    main_vld_d = main_vld_q;
    main_imm_d = main_imm_q;
    main_fmt_d = main_fmt_q;
    main_ill_d = main_ill_q;
    skid_vld_d = skid_vld_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    cnt_d      = cnt_q;

    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (!main_vld_q || deliver) begin
        if (skid_vld_q) begin
          main_vld_d = 1'b1;
          main_imm_d = skid_imm_q;
          main_fmt_d = skid_fmt_q;
          main_ill_d = skid_ill_q;
          skid_vld_d = 1'b0;
        end else if (accept) begin
          main_vld_d = 1'b1;
          main_imm_d = dec_imm;
          main_fmt_d = dec_fmt;
          main_ill_d = dec_ill;
        end else begin
          main_vld_d = 1'b0;
        end
      end else if (accept) begin
        skid_vld_d = 1'b1;
        skid_imm_d = dec_imm;
        skid_fmt_d = dec_fmt;
        skid_ill_d = dec_ill;
      end

      if (deliver && main_ill_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_imm_q <= '0;
      main_fmt_q <= FMT_NONE;
      main_ill_q <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
      skid_ill_q <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_imm_q <= main_imm_d;
      main_fmt_q <= main_fmt_d;
      main_ill_q <= main_ill_d;
      skid_vld_q <= skid_vld_d;
      skid_imm_q <= skid_imm_d;
      skid_fmt_q <= skid_fmt_d;
      skid_ill_q <= skid_ill_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_vld_q;
  assign imm         = main_imm_q;
  assign fmt         = main_fmt_q;
  assign illegal     = main_ill_q;
  assign illegal_cnt = cnt_q;

endmodule
